// File: rtl/reg_fifo_pkg.sv
// reg_fifo_pkg: shared types, read-mode constants and width helper for the register FIFO family
package reg_fifo_pkg;
  localparam bit MODE_FWFT = 1'b1;
  localparam bit MODE_REG = 1'b0;
  typedef struct packed {
    logic overrun;
    logic underrun;
  } err_flags_t;
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/reg_fifo_ctrl.sv
// reg_fifo_ctrl: pointers, occupancy, accept/flush logic, sticky errors and peak watermark
module reg_fifo_ctrl
  import reg_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = cnt_width(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             err_clr_i,
  input  logic [CNT_W-1:0] af_thr_i,
  input  logic [CNT_W-1:0] ae_thr_i,
  output logic             wr_en_o,
  output logic             rd_en_o,
  output logic [PW-1:0]    wr_ptr_o,
  output logic [PW-1:0]    rd_ptr_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] peak_o,
  output err_flags_t       err_o,
  output logic             af_o,
  output logic             ae_o
);
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, peak_q, peak_d;
  err_flags_t err_q, err_d;
  logic ovr_ev, und_ev;
  always_comb begin
    full_o = cnt_q == CNT_W'(DEPTH);
    empty_o = cnt_q == '0;
    // a pop frees the slot the simultaneous push lands in, so full does not block it
    wr_en_o = !flush_i & push_i & (!full_o | pop_i);
    rd_en_o = !flush_i & pop_i & !empty_o;
    ovr_ev = !flush_i & push_i & full_o & !pop_i;
    und_ev = !flush_i & pop_i & empty_o;
    wr_d = flush_i ? '0 : wr_q + PW'(wr_en_o);
    rd_d = flush_i ? '0 : rd_q + PW'(rd_en_o);
    cnt_d = flush_i ? '0 : cnt_q + CNT_W'(wr_en_o) - CNT_W'(rd_en_o);
    peak_d = err_clr_i ? cnt_d : (cnt_d > peak_q ? cnt_d : peak_q);
    err_d.overrun = ovr_ev | (err_q.overrun & !err_clr_i);
    err_d.underrun = und_ev | (err_q.underrun & !err_clr_i);
    wr_ptr_o = wr_q;
    rd_ptr_o = rd_q;
    cnt_o = cnt_q;
    peak_o = peak_q;
    err_o = err_q;
    af_o = cnt_q >= af_thr_i;
    ae_o = cnt_q <= ae_thr_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      peak_q <= '0;
      err_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      peak_q <= peak_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/gen_reg_fifo_flex.sv
// gen_reg_fifo_flex: parametrised flop-array FIFO with FWFT or registered read,
// flush, sticky error flags and peak-occupancy watermark
module gen_reg_fifo_flex
  import reg_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64,
  parameter bit FWFT = MODE_FWFT,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clockCore,
  input  logic             resetCore,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             pop,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataValid,
  output logic             full,
  output logic             empty,
  input  logic [CNT_W-1:0] almostFullThreshold,
  input  logic [CNT_W-1:0] almostEmptyThreshold,
  output logic             almostFullFlag,
  output logic             almostEmptyFlag,
  output logic [CNT_W-1:0] fifoDepth,
  output logic [CNT_W-1:0] peakDepth,
  output logic             overrun,
  output logic             underrun,
  input  logic             errClear
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q, dout_d, head;
  logic dv_q, wr_en, rd_en;
  logic [PW-1:0] wr_ptr, rd_ptr;
  err_flags_t err;
  reg_fifo_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_ctrl (
    .clk(clockCore), .rst(resetCore), .flush_i(flush), .push_i(push), .pop_i(pop),
    .err_clr_i(errClear), .af_thr_i(almostFullThreshold), .ae_thr_i(almostEmptyThreshold),
    .wr_en_o(wr_en), .rd_en_o(rd_en), .wr_ptr_o(wr_ptr), .rd_ptr_o(rd_ptr),
    .full_o(full), .empty_o(empty), .cnt_o(fifoDepth), .peak_o(peakDepth),
    .err_o(err), .af_o(almostFullFlag), .ae_o(almostEmptyFlag)
  );
  always_ff @(posedge clockCore) begin
    if (wr_en) mem_q[wr_ptr] <= dataIn;
  end
  always_comb begin
    head = mem_q[rd_ptr];
    dout_d = flush ? '0 : (rd_en ? head : dout_q);
    dataOut = (FWFT == MODE_FWFT) ? (empty ? '0 : head) : dout_q;
    dataValid = (FWFT == MODE_FWFT) ? !empty : dv_q;
    overrun = err.overrun;
    underrun = err.underrun;
  end
  always_ff @(posedge clockCore or posedge resetCore) begin
    if (resetCore) begin
      dout_q <= '0;
      dv_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      dv_q <= rd_en;
    end
  end
endmodule

// File: tb/tb_gen_reg_fifo_flex.sv
// tb_gen_reg_fifo_flex: FWFT and registered-read instances driven in lockstep,
// checked against directed vectors and a queue-based reference model
module tb_gen_reg_fifo_flex;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  logic clk = 0, rst = 1, flush = 0, push = 0, pop = 0, clr = 0;
  logic [63:0] din = '0;
  logic [CW-1:0] afth = 4'd6, aeth = 4'd2;
  logic [63:0] d1_out, d0_out;
  logic d1_dv, d1_full, d1_empty, d1_af, d1_ae, d1_ovr, d1_und;
  logic d0_dv, d0_full, d0_empty, d0_af, d0_ae, d0_ovr, d0_und;
  logic [CW-1:0] d1_dep, d1_pk, d0_dep, d0_pk;
  int tests = 0, fails = 0;
  logic [63:0] q[$];
  int peak;
  bit ovr, und, dv0;
  logic [63:0] dout0;

  typedef struct {
    bit p, o, f, c;
    logic [63:0] d;
    int dep, pk;
    bit ov, un;
    logic [63:0] o1, o0;
    bit v0;
  } vec_t;
  vec_t tbl[22];

  always #5 clk = ~clk;

  gen_reg_fifo_flex #(.DEPTH(8), .WIDTH(64), .FWFT(1)) dut1 (
    .clockCore(clk), .resetCore(rst), .flush(flush), .push(push), .dataIn(din), .pop(pop),
    .dataOut(d1_out), .dataValid(d1_dv), .full(d1_full), .empty(d1_empty),
    .almostFullThreshold(afth), .almostEmptyThreshold(aeth),
    .almostFullFlag(d1_af), .almostEmptyFlag(d1_ae), .fifoDepth(d1_dep), .peakDepth(d1_pk),
    .overrun(d1_ovr), .underrun(d1_und), .errClear(clr));
  gen_reg_fifo_flex #(.DEPTH(8), .WIDTH(64), .FWFT(0)) dut0 (
    .clockCore(clk), .resetCore(rst), .flush(flush), .push(push), .dataIn(din), .pop(pop),
    .dataOut(d0_out), .dataValid(d0_dv), .full(d0_full), .empty(d0_empty),
    .almostFullThreshold(afth), .almostEmptyThreshold(aeth),
    .almostFullFlag(d0_af), .almostEmptyFlag(d0_ae), .fifoDepth(d0_dep), .peakDepth(d0_pk),
    .overrun(d0_ovr), .underrun(d0_und), .errClear(clr));

  function automatic vec_t mk(bit p, bit o, bit f, bit c, logic [63:0] d, int dep, int pk,
                              bit ov, bit un, logic [63:0] o1, logic [63:0] o0, bit v0);
    vec_t v;
    v.p = p; v.o = o; v.f = f; v.c = c; v.d = d; v.dep = dep; v.pk = pk;
    v.ov = ov; v.un = un; v.o1 = o1; v.o0 = o0; v.v0 = v0;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete(); peak = 0; ovr = 0; und = 0; dv0 = 0; dout0 = '0;
  endtask

  task automatic model_upd(bit p, bit o, bit f, bit c, logic [63:0] d);
    int n = q.size();
    bit oe = 0, ue = 0;
    if (f) begin
      q.delete(); dv0 = 0; dout0 = '0;
    end else begin
      oe = p && n == DEPTH && !o;
      ue = o && n == 0;
      if (o && n > 0) begin dout0 = q.pop_front(); dv0 = 1; end else dv0 = 0;
      if (p && (n < DEPTH || o)) q.push_back(d);
    end
    ovr = oe | (ovr & !c);
    und = ue | (und & !c);
    peak = c ? q.size() : (q.size() > peak ? q.size() : peak);
  endtask

  task automatic model_chk(string t);
    int n = q.size();
    chk({t, " depth"}, d1_dep, n);
    chk({t, " depth0"}, d0_dep, n);
    chk({t, " full"}, d1_full, n == DEPTH);
    chk({t, " empty"}, d1_empty, n == 0);
    chk({t, " empty0"}, d0_empty, n == 0);
    chk({t, " afull"}, d1_af, n >= int'(afth));
    chk({t, " aempty"}, d1_ae, n <= int'(aeth));
    chk({t, " peak"}, d1_pk, peak);
    chk({t, " peak0"}, d0_pk, peak);
    chk({t, " ovr"}, {d1_ovr, d0_ovr}, {ovr, ovr});
    chk({t, " und"}, {d1_und, d0_und}, {und, und});
    chk({t, " dout_fwft"}, d1_out, n > 0 ? q[0] : 64'h0);
    chk({t, " dv_fwft"}, d1_dv, n > 0);
    chk({t, " dout_reg"}, d0_out, dout0);
    chk({t, " dv_reg"}, d0_dv, dv0);
  endtask

  task automatic step(bit p, bit o, bit f, bit c, logic [63:0] d);
    push = p; pop = o; flush = f; clr = c; din = d;
    @(posedge clk);
    model_upd(p, o, f, c, d);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = mk(1, 0, 0, 0, 64'(i + 1), i + 1, i + 1, 0, 0, 64'h1, 64'h0, 0);
    tbl[8] = mk(1, 0, 0, 0, 64'h9, 8, 8, 1, 0, 64'h1, 64'h0, 0);
    for (int k = 1; k <= 8; k++)
      tbl[8 + k] = mk(0, 1, 0, 0, 64'h0, 8 - k, 8, 1, 0, k < 8 ? 64'(k + 1) : 64'h0, 64'(k), 1);
    tbl[17] = mk(0, 1, 0, 0, 64'h0, 0, 8, 1, 1, 64'h0, 64'h8, 0);
    tbl[18] = mk(1, 1, 0, 0, 64'h33, 1, 8, 1, 1, 64'h33, 64'h8, 0);
    tbl[19] = mk(0, 1, 0, 0, 64'h0, 0, 8, 1, 1, 64'h0, 64'h33, 1);
    tbl[20] = mk(0, 1, 0, 1, 64'h0, 0, 0, 0, 1, 64'h0, 64'h33, 0);
    tbl[21] = mk(0, 0, 0, 1, 64'h0, 0, 0, 0, 0, 64'h0, 64'h33, 0);

    model_reset();
    #2;
    model_chk("reset");
    chk("reset afull", d1_af, 1'b0);
    chk("reset aempty", d1_ae, 1'b1);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].p, tbl[i].o, tbl[i].f, tbl[i].c, tbl[i].d);
      chk($sformatf("vec%0d depth", i), d1_dep, tbl[i].dep);
      chk($sformatf("vec%0d peak", i), d1_pk, tbl[i].pk);
      chk($sformatf("vec%0d ovr", i), d1_ovr, tbl[i].ov);
      chk($sformatf("vec%0d und", i), d1_und, tbl[i].un);
      chk($sformatf("vec%0d dout_fwft", i), d1_out, tbl[i].o1);
      chk($sformatf("vec%0d dout_reg", i), d0_out, tbl[i].o0);
      chk($sformatf("vec%0d dv_reg", i), d0_dv, tbl[i].v0);
      chk($sformatf("vec%0d full", i), d1_full, tbl[i].dep == 8);
    end

    for (int i = 0; i < 8; i++) begin step(1, 0, 0, 0, 64'hB000 + 64'(i)); model_chk("fill"); end
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0, 0, 64'hA500 + 64'(i));
      model_chk("wrap");
      chk("wrap depth", d1_dep, 4'd8);
      chk("wrap ovr", d1_ovr, 1'b0);
    end
    step(0, 0, 1, 0, 0); model_chk("flush1");

    afth = 4'd6; aeth = 4'd2;
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 0, 0, 64'hC0 + 64'(i));
      model_chk("afill");
      chk($sformatf("afull at %0d", i), d1_af, i >= 6);
    end
    for (int i = 0; i < 4; i++) begin step(0, 1, 0, 0, 0); model_chk("adrain"); end
    chk("aempty at 2", d1_ae, 1'b1);
    chk("aempty depth", d1_dep, 4'd2);
    step(0, 0, 1, 0, 0);

    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 64'hD0 + 64'(i));
    step(1, 1, 1, 0, 64'hEE);
    model_chk("flushpush");
    chk("flush depth", d1_dep, 4'd0);
    chk("flush empty", d1_empty, 1'b1);
    chk("flush peak", d1_pk, 4'd5);
    chk("flush und kept", d1_und, 1'b1);
    chk("flush ovr", d1_ovr, 1'b0);
    chk("flush dv_reg", d0_dv, 1'b0);
    step(0, 0, 0, 0, 0); model_chk("postflush");

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        afth = CW'($urandom_range(0, 9)); aeth = CW'($urandom_range(0, 9));
      end
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0,
           $urandom_range(0, 20) == 0, {$urandom, $urandom});
      model_chk("rand");
    end

    step(1, 0, 0, 0, 64'h11);
    step(1, 0, 0, 0, 64'h22);
    step(0, 1, 0, 0, 0);
    model_chk("midrst pre");
    rst = 1;
    #1;
    model_reset();
    model_chk("midrst");
    chk("midrst dout_reg", d0_out, 64'h0);
    chk("midrst dv_reg", d0_dv, 1'b0);
    @(negedge clk); rst = 0; push = 0; pop = 0;
    @(posedge clk); #1;
    model_chk("after rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
